// File: rtl/uart_io_bridge.sv
// Bridges the MMU byte-wide IO handshake to an AXI4-Lite UART Lite: polls STAT,
// buffers RX bytes in a small FIFO, forwards TX bytes and keeps sticky error flags.
module uart_io_bridge #(
  parameter logic [31:0] UART_BASE = 32'h4060_0000,
  parameter int          RX_DEPTH  = 4,
  parameter int          POLL_GAP  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [7:0]  io_in_data,
  output logic        io_in_vld,
  input  logic        io_in_rdy,
  input  logic [7:0]  io_out_data,
  input  logic        io_out_vld,
  output logic        io_out_rdy,
  output logic [4:0]  io_err
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(RX_DEPTH);
  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP + 1);

  typedef enum logic [3:0] {
    INIT_AW, INIT_B, GAP, STAT_AR, STAT_R, RX_AR, RX_R, TX_AW, TX_B
  } state_t;

  // Every channel is valid/ready: a beat transfers on the rising edge where both are high.
  state_t        state, state_n;
  logic [15:0]   gap_cnt, gap_cnt_n;
  logic          aw_done, aw_done_n, w_done, w_done_n;
  logic [31:0]   araddr_n, awaddr_n, wdata_n;
  logic [3:0]    wstrb_n;
  logic          arvalid_n, rready_n, awvalid_n, wvalid_n, bready_n;
  logic [7:0]    hold, hold_n;
  logic          hold_full, hold_full_n, init_done, init_done_n, out_rdy_n;
  logic [4:0]    err_n;
  logic [7:0]    mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_n;
  logic [AW:0]   count, count_n;
  logic [7:0]    in_data_n;
  logic          push, pop, fifo_full;
  logic          unused_ok;

  assign unused_ok = ^{m_axi_rdata[31:8], m_axi_rresp[0], m_axi_bresp[0]};
  assign fifo_full = (count == FULL);

  always_comb begin
    state_n = state;  gap_cnt_n = gap_cnt;  aw_done_n = aw_done;  w_done_n = w_done;
    araddr_n = m_axi_araddr;  arvalid_n = m_axi_arvalid;  rready_n = m_axi_rready;
    awaddr_n = m_axi_awaddr;  awvalid_n = m_axi_awvalid;  wvalid_n = m_axi_wvalid;
    wdata_n = m_axi_wdata;  wstrb_n = m_axi_wstrb;  bready_n = m_axi_bready;
    hold_n = hold;  hold_full_n = hold_full;  init_done_n = init_done;
    err_n = io_err;  push = 1'b0;
    if (io_out_vld && io_out_rdy) begin
      hold_n = io_out_data;
      hold_full_n = 1'b1;
    end
    if ((m_axi_rvalid && m_axi_rready && m_axi_rresp[1]) ||
        (m_axi_bvalid && m_axi_bready && m_axi_bresp[1])) err_n[4] = 1'b1;
    case (state)
      INIT_AW, TX_AW: begin
        awaddr_n = UART_BASE + ((state == INIT_AW) ? 32'hC : 32'h4);
        wdata_n  = (state == INIT_AW) ? 32'h0000_0003 : {24'b0, hold};
        wstrb_n  = 4'b0001;
        // AW and W are raised together on entry and each drops on its own ready.
        if (!aw_done) begin
          if (m_axi_awvalid && m_axi_awready) begin
            awvalid_n = 1'b0;
            aw_done_n = 1'b1;
          end else awvalid_n = 1'b1;
        end
        if (!w_done) begin
          if (m_axi_wvalid && m_axi_wready) begin
            wvalid_n = 1'b0;
            w_done_n = 1'b1;
          end else wvalid_n = 1'b1;
        end
        if (aw_done_n && w_done_n) begin
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          bready_n  = 1'b1;
          state_n   = (state == INIT_AW) ? INIT_B : TX_B;
        end
      end
      INIT_B, TX_B: begin
        if (m_axi_bvalid) begin
          bready_n  = 1'b0;
          gap_cnt_n = '0;
          state_n   = GAP;
          if (state == INIT_B) init_done_n = 1'b1;
          else hold_full_n = 1'b0;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          araddr_n  = UART_BASE + 32'h8;
          arvalid_n = 1'b1;
          state_n   = STAT_AR;
        end else gap_cnt_n = gap_cnt + 16'd1;
      end
      STAT_AR, RX_AR: begin
        if (m_axi_arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = (state == STAT_AR) ? STAT_R : RX_R;
        end
      end
      STAT_R: begin
        if (m_axi_rvalid) begin
          rready_n   = 1'b0;
          err_n[3:1] = err_n[3:1] | m_axi_rdata[7:5];
          if (m_axi_rdata[1] && fifo_full) err_n[0] = 1'b1;
          if (m_axi_rdata[0] && !fifo_full) begin
            araddr_n  = UART_BASE;
            arvalid_n = 1'b1;
            state_n   = RX_AR;
          end else if (hold_full && !m_axi_rdata[3]) begin
            state_n = TX_AW;
          end else begin
            gap_cnt_n = '0;
            state_n   = GAP;
          end
        end
      end
      RX_R: begin
        if (m_axi_rvalid) begin
          rready_n  = 1'b0;
          push      = 1'b1;
          gap_cnt_n = '0;
          state_n   = hold_full ? TX_AW : GAP;
        end
      end
      default: state_n = INIT_AW;
    endcase
    out_rdy_n = init_done_n && !hold_full_n;

    pop      = io_in_vld && io_in_rdy && (count != '0);
    count_n  = count + (AW+1)'(push) - (AW+1)'(pop);
    rd_ptr_n = rd_ptr + AW'(pop);
    // When the FIFO drains to nothing in the same cycle as a push, the new head
    // has not reached memory yet, so take it straight from the read data.
    in_data_n = io_in_data;
    if (count_n != '0)
      in_data_n = (count == (AW+1)'(pop)) ? m_axi_rdata[7:0] : mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT_AW;  gap_cnt <= '0;  aw_done <= 1'b0;  w_done <= 1'b0;
      m_axi_araddr <= '0;  m_axi_arvalid <= 1'b0;  m_axi_rready <= 1'b0;
      m_axi_awaddr <= '0;  m_axi_awvalid <= 1'b0;  m_axi_wvalid <= 1'b0;
      m_axi_wdata <= '0;  m_axi_wstrb <= '0;  m_axi_bready <= 1'b0;
      hold <= '0;  hold_full <= 1'b0;  init_done <= 1'b0;  io_out_rdy <= 1'b0;
      io_err <= '0;  wr_ptr <= '0;  rd_ptr <= '0;  count <= '0;
      io_in_vld <= 1'b0;  io_in_data <= '0;
    end else begin
      state <= state_n;  gap_cnt <= gap_cnt_n;  aw_done <= aw_done_n;  w_done <= w_done_n;
      m_axi_araddr <= araddr_n;  m_axi_arvalid <= arvalid_n;  m_axi_rready <= rready_n;
      m_axi_awaddr <= awaddr_n;  m_axi_awvalid <= awvalid_n;  m_axi_wvalid <= wvalid_n;
      m_axi_wdata <= wdata_n;  m_axi_wstrb <= wstrb_n;  m_axi_bready <= bready_n;
      hold <= hold_n;  hold_full <= hold_full_n;  init_done <= init_done_n;
      io_out_rdy <= out_rdy_n;  io_err <= err_n;
      wr_ptr <= wr_ptr + AW'(push);  rd_ptr <= rd_ptr_n;  count <= count_n;
      io_in_vld <= (count_n != '0);  io_in_data <= in_data_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= m_axi_rdata[7:0];
  end

endmodule

// File: doc/uart_io_bridge.md
# uart_io_bridge

Converts the MMU's byte-wide IO handshake (`io_in_*`, `io_out_*`, `io_err`) into AXI4-Lite accesses to an AXI UART Lite peripheral. It sits directly downstream of the MMU's UART path: the MMU maps core accesses at 0x80000000/0x80000004 onto the io ports, and this block polls the UART, buffers received bytes, forwards transmit bytes and reports sticky error flags.

## Interface
Parameters:
- `UART_BASE`, 32'h4060_0000 — AXI base address of the UART Lite; registers at +0x0 RX, +0x4 TX, +0x8 STAT, +0xC CTRL.
- `RX_DEPTH`, 4 — receive FIFO depth in bytes; power of two, ≥ 2.
- `POLL_GAP`, 16 — idle cycles between status polls; 0 is legal.

Ports (one synchronous clock domain; reset is synchronous and active-high):
- `clk` in 1 — clock.
- `rst` in 1 — synchronous active-high reset.
- `m_axi_araddr` out 32, `m_axi_arvalid` out 1, `m_axi_arready` in 1 — read address channel.
- `m_axi_rdata` in 32, `m_axi_rresp` in 2, `m_axi_rvalid` in 1, `m_axi_rready` out 1 — read data channel.
- `m_axi_awaddr` out 32, `m_axi_awvalid` out 1, `m_axi_awready` in 1 — write address channel.
- `m_axi_wdata` out 32, `m_axi_wstrb` out 4, `m_axi_wvalid` out 1, `m_axi_wready` in 1 — write data channel.
- `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1 — write response channel.
- `io_in_data` out 8 — head of the RX FIFO.
- `io_in_vld` out 1 — RX FIFO not empty.
- `io_in_rdy` in 1 — MMU pops the head byte when `io_in_vld && io_in_rdy`.
- `io_out_data` in 8 — transmit byte from the MMU.
- `io_out_vld` in 1 — transmit byte valid.
- `io_out_rdy` out 1 — TX holding register empty and init done.
- `io_err` out 5 — sticky flags {resp1, parity, frame, overrun, lost}.

## Operation
- The FSM has these states: INIT_AW, INIT_B, GAP, STAT_AR, STAT_R, RX_AR, RX_R, TX_AW, TX_B.
- **INIT_AW**: entered from reset. Write 0x0000_0003 (reset TX and RX FIFOs) to CTRL with `wstrb`=4'b0001. AW and W are raised together; each valid drops independently on its ready. When both have dropped, assert `bready` and go to INIT_B.
- **INIT_B**: on `bvalid`, drop `bready` and go to GAP. `io_out_rdy` may rise from this point.
- **GAP**: count POLL_GAP cycles, then go to STAT_AR. A pending TX byte does not shorten the gap.
- **STAT_AR**: `araddr`=BASE+8 with `arvalid`=1. On `arready`, drop `arvalid`, raise `rready`, go to STAT_R.
- **STAT_R**: on `rvalid`, drop `rready`, then:
  - OR `rdata[7]`→parity, `rdata[6]`→frame, `rdata[5]`→overrun into `io_err`.
  - If `rdata[0]` (rx valid) and the FIFO is not full, go to RX_AR.
  - Else if the TX holding register is full and `rdata[3]`=0 (tx not full), go to TX_AW.
  - Else go to GAP.
  - `lost` is set when `rdata[1]` (UART RX FIFO full) and the bridge FIFO is full.
- **RX_AR / RX_R**: read BASE+0 with the same handshake as STAT. Push `rdata[7:0]` into the FIFO, then go to TX_AW if a TX byte is pending, else GAP.
- **TX_AW / TX_B**: write `{24'b0, hold}` to BASE+4 with `wstrb`=4'b0001 and the same AW/W/B handshake as INIT. On `bvalid`, clear the holding register and go to GAP.
- **resp1**: set on any `rresp[1]` or `bresp[1]`. The transaction is still treated as complete; on an RX read, the byte is pushed anyway.
- **TX holding register**: loaded when `io_out_vld && io_out_rdy`. `io_out_rdy` drops the following cycle.
- **RX FIFO**: circular, with wrapping pointers and an occupancy counter of width log2(RX_DEPTH)+1.
  - A push and a pop in the same cycle are both performed.
  - A pop when empty is ignored.
  - A push is never issued while full, because STAT_R checks.
- **`io_err`**: cleared only by `rst`.

## Timing
- **Reset values**: all `m_axi_*` valid/ready outputs are 0; addresses, `wdata` and `wstrb` are 0; `io_in_vld`=0, `io_in_data`=0, `io_out_rdy`=0, `io_err`=0. The FSM is in INIT_AW, which raises `awvalid`/`wvalid` on the first cycle after `rst` deasserts.
- **Reset mid-transaction**: abandons the transaction immediately; all outputs return to reset values in the next cycle.
- **Outputs**: all are registered; none is combinational from an input.
- **RX latency**: `io_in_vld` rises 1 cycle after the RX `rvalid` beat. A byte popped in cycle N changes `io_in_data` in N+1.
- **TX acceptance**: `io_out_rdy` rises the cycle after INIT_B completes and the cycle after the TX `bvalid`.
- **Minimum poll period**: POLL_GAP + 4 cycles when slaves respond with zero wait.

## Test plan
- Reset release, slave always ready → exactly one write to 0x4060000C with `wdata`=0x3, `wstrb`=0x1; `io_out_rdy`=1 afterwards; then STAT reads every POLL_GAP+4 cycles.
- STAT returns 0x01, RX returns 0x41 → `io_in_vld`=1 with `io_in_data`=0x41; pop with `io_in_rdy` → `io_in_vld`=0 next cycle.
- MMU sends 0x5A while STAT reports 0x00 → write 0x0000005A to 0x40600004; `io_out_rdy` returns to 1 after `bvalid`. With STAT=0x08 (tx full), no write until STAT clears bit 3.
- Fill 4 bytes without popping, STAT=0x03 → no further RX reads, `io_err[0]`=1. Pop one → next poll reads RX.
- STAT=0xE0, then `rresp`=2'b10 on an RX read → `io_err`=5'b11110, and the byte is still pushed; flags persist through later clean polls until `rst`.
- Assert `rst` during TX_AW with `awready` held low → `awvalid`/`wvalid` are 0 next cycle, and INIT repeats.
